dp_job_sequencer: RTL

Parametrised batch sequencer for the AXI-Lite dot-product accelerator. It latches a job descriptor, runs FETCH → COMPUTE → WRITE → READ for each of up to 255 dot-products in a batch, and advances the addresses by a programmable stride between jobs. Each phase has a watchdog that detects a hung datapath. It sits between the AXI-Lite register front end and the fetch/compute/store/read engines, replacing the fixed single-job controller.

---
 rtl/dp_pkg.sv | 25 ++
 rtl/dp_phase_timer.sv | 29 ++
 rtl/dp_job_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/dp_pkg.sv
// Shared types and constants for the dot-product batch sequencer.
package dp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_COMPUTE,
    S_WRITE,
    S_READ,
    S_NEXT,
    S_ERROR
  } state_e;

  localparam logic [1:0] PH_FETCH   = 2'd0;
  localparam logic [1:0] PH_COMPUTE = 2'd1;
  localparam logic [1:0] PH_WRITE   = 2'd2;
  localparam logic [1:0] PH_READ    = 2'd3;

  localparam int unsigned DP_ADDR_W = 32;
  localparam int unsigned DP_DATA_W = 32;
  localparam int unsigned DP_LEN_W  = 16;
  localparam int unsigned DP_TMO_W  = 16;

endpackage

// File: rtl/dp_phase_timer.sv
// Per-phase watchdog counter: cleared on phase entry, counts while in a phase.
module dp_phase_timer
  import dp_pkg::*;
#(
  parameter int unsigned TMO_W = DP_TMO_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);

  logic [TMO_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + TMO_W'(1);
    end
  end

  assign expired = (limit != '0) && (cnt_q == limit);

endmodule

// File: rtl/dp_job_sequencer.sv
// Batch sequencer: runs FETCH/COMPUTE/WRITE/READ per job with strided addresses,
// a per-phase watchdog and read-back capture. All outputs are registered.
module dp_job_sequencer
  import dp_pkg::*;
#(
  parameter int unsigned ADDR_W = DP_ADDR_W,
  parameter int unsigned DATA_W = DP_DATA_W,
  parameter int unsigned LEN_W  = DP_LEN_W,
  parameter int unsigned TMO_W  = DP_TMO_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_a_addr,
  input  logic [ADDR_W-1:0] cfg_b_addr,
  input  logic [ADDR_W-1:0] cfg_out_addr,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [7:0]        cfg_jobs,
  input  logic [TMO_W-1:0]  cfg_timeout,
  output logic [ADDR_W-1:0] cmd_a_addr,
  output logic [ADDR_W-1:0] cmd_b_addr,
  output logic [ADDR_W-1:0] cmd_out_addr,
  output logic [LEN_W-1:0]  cmd_len,
  output logic              start_fetch,
  output logic              start_compute,
  output logic              start_write,
  output logic              start_read,
  input  logic              fetch_done,
  input  logic              processing_done,
  input  logic              store_done,
  input  logic              read_done,
  input  logic [DATA_W-1:0] rd_data_in,
  input  logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              batch_done,
  output logic              aborted,
  output logic              error,
  output logic [1:0]        err_phase,
  output logic [7:0]        job_idx
);

  localparam logic [ADDR_W-1:0] OUT_STEP = ADDR_W'(DATA_W / 8);

  state_e            state_q;
  logic              first_q;
  logic [ADDR_W-1:0] cmd_a_q, cmd_b_q, cmd_out_q, stride_q;
  logic [LEN_W-1:0]  len_q;
  logic [7:0]        jobs_q, job_idx_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              start_fetch_q, start_compute_q, start_write_q, start_read_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rdata_valid_q, busy_q, batch_done_q, aborted_q, error_q;
  logic [1:0]        err_phase_q;

  logic              in_phase, done_sel, accept, expired, last_job;
  logic [1:0]        ph_code;
  state_e            phase_nxt;

  always_comb begin
    in_phase  = 1'b1;
    done_sel  = 1'b0;
    ph_code   = PH_FETCH;
    phase_nxt = S_NEXT;
    case (state_q)
      S_FETCH: begin
        done_sel  = fetch_done;
        phase_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        done_sel  = processing_done;
        ph_code   = PH_COMPUTE;
        phase_nxt = S_WRITE;
      end
      S_WRITE: begin
        done_sel  = store_done;
        ph_code   = PH_WRITE;
        phase_nxt = S_READ;
      end
      S_READ: begin
        done_sel  = read_done;
        ph_code   = PH_READ;
        phase_nxt = S_NEXT;
      end
      default: in_phase = 1'b0;
    endcase
  end

  // A done coinciding with the start pulse belongs to the previous request.
  assign accept   = in_phase && !first_q && done_sel;
  assign last_job = ({1'b0, job_idx_q} + 9'd1) >= {1'b0, jobs_q};

  dp_phase_timer #(
    .TMO_W(TMO_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (!in_phase || accept),
    .en     (in_phase),
    .limit  (tmo_q),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      first_q         <= 1'b0;
      cmd_a_q         <= '0;
      cmd_b_q         <= '0;
      cmd_out_q       <= '0;
      stride_q        <= '0;
      len_q           <= '0;
      jobs_q          <= '0;
      tmo_q           <= '0;
      job_idx_q       <= '0;
      start_fetch_q   <= 1'b0;
      start_compute_q <= 1'b0;
      start_write_q   <= 1'b0;
      start_read_q    <= 1'b0;
      rdata_q         <= '0;
      rdata_valid_q   <= 1'b0;
      busy_q          <= 1'b0;
      batch_done_q    <= 1'b0;
      aborted_q       <= 1'b0;
      error_q         <= 1'b0;
      err_phase_q     <= '0;
    end else begin
      start_fetch_q   <= 1'b0;
      start_compute_q <= 1'b0;
      start_write_q   <= 1'b0;
      start_read_q    <= 1'b0;
      batch_done_q    <= 1'b0;
      aborted_q       <= 1'b0;
      rdata_valid_q   <= 1'b0;
      first_q         <= 1'b0;

      if (state_q == S_READ && rvalid) begin
        rdata_q       <= rd_data_in;
        rdata_valid_q <= 1'b1;
      end

      // Abort overrides every transition below, so no start pulse is scheduled.
      if (abort && state_q != S_IDLE) begin
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
        aborted_q   <= 1'b1;
        error_q     <= 1'b0;
        err_phase_q <= PH_FETCH;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q <= S_LOAD;
              busy_q  <= 1'b1;
            end
          end
          S_LOAD: begin
            cmd_a_q       <= cfg_a_addr;
            cmd_b_q       <= cfg_b_addr;
            cmd_out_q     <= cfg_out_addr;
            stride_q      <= cfg_stride;
            len_q         <= cfg_len;
            jobs_q        <= (cfg_jobs == 8'd0) ? 8'd1 : cfg_jobs;
            tmo_q         <= cfg_timeout;
            job_idx_q     <= '0;
            state_q       <= S_FETCH;
            start_fetch_q <= 1'b1;
            first_q       <= 1'b1;
          end
          S_FETCH, S_COMPUTE, S_WRITE, S_READ: begin
            if (accept) begin
              state_q         <= phase_nxt;
              first_q         <= (phase_nxt != S_NEXT);
              start_compute_q <= (phase_nxt == S_COMPUTE);
              start_write_q   <= (phase_nxt == S_WRITE);
              start_read_q    <= (phase_nxt == S_READ);
            end else if (expired) begin
              state_q     <= S_ERROR;
              error_q     <= 1'b1;
              err_phase_q <= ph_code;
            end
          end
          S_NEXT: begin
            if (last_job) begin
              state_q      <= S_IDLE;
              busy_q       <= 1'b0;
              batch_done_q <= 1'b1;
            end else begin
              job_idx_q     <= job_idx_q + 8'd1;
              cmd_a_q       <= cmd_a_q + stride_q;
              cmd_b_q       <= cmd_b_q + stride_q;
              cmd_out_q     <= cmd_out_q + OUT_STEP;
              state_q       <= S_FETCH;
              start_fetch_q <= 1'b1;
              first_q       <= 1'b1;
            end
          end
          S_ERROR: ;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign cmd_a_addr    = cmd_a_q;
  assign cmd_b_addr    = cmd_b_q;
  assign cmd_out_addr  = cmd_out_q;
  assign cmd_len       = len_q;
  assign start_fetch   = start_fetch_q;
  assign start_compute = start_compute_q;
  assign start_write   = start_write_q;
  assign start_read    = start_read_q;
  assign rdata         = rdata_q;
  assign rdata_valid   = rdata_valid_q;
  assign busy          = busy_q;
  assign batch_done    = batch_done_q;
  assign aborted       = aborted_q;
  assign error         = error_q;
  assign err_phase     = err_phase_q;
  assign job_idx       = job_idx_q;

endmodule
